// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        WRITE = 3'd3,
        CKSUM = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 4;

    // Number of words the instruction memory can hold.
    function automatic logic [31:0] im_capacity(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/instr_word_packer.sv
// Shift-assembles a big-endian byte stream into 32-bit words (header or payload).
module instr_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hdr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [23:0] shift;
    logic [1:0]  cnt;
    logic [1:0]  last_cnt;

    assign last_cnt  = hdr ? 2'(HDR_BYTES - 1) : 2'(BYTES_PER_WORD - 1);
    // The word is complete combinationally on the edge that takes its final byte.
    assign word      = {shift, byte_in};
    assign word_full = byte_en && (cnt == last_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shift <= '0;
            cnt   <= '0;
        end else if (byte_en) begin
            shift <= {shift[15:0], byte_in};
            cnt   <= word_full ? 2'd0 : cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Boot loader: streams a counted program into instruction memory while holding the CPU in reset.
// Optional trailing XOR checksum byte enabled by defining INSTR_LOADER_CKSUM_EN.
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              im_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] CAPACITY = im_capacity(ADDR_W);

    state_t          state;
    logic [31:0]     count;
    logic [ADDR_W:0] idx;
    logic            byte_en;
    logic            pack_en;
    logic            start_ok;
    logic            last_word;
    logic [31:0]     word;
    logic            word_full;
`ifdef INSTR_LOADER_CKSUM_EN
    logic [7:0]      cksum;
`endif

    assign rx_ready  = (state == HDR) || (state == LOAD) || (state == CKSUM);
    assign byte_en   = rx_valid && rx_ready;
    assign pack_en   = byte_en && (state != CKSUM);
    assign start_ok  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
    // idx is zero-extended so a full-capacity load never wraps the comparison.
    assign last_word = (32'(idx) == (count - 32'd1));

    instr_word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .hdr       (state == HDR),
        .byte_en   (pack_en),
        .byte_in   (rx_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            count    <= '0;
            idx      <= '0;
`ifdef INSTR_LOADER_CKSUM_EN
            cksum    <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= HDR;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        count    <= '0;
                        idx      <= '0;
`ifdef INSTR_LOADER_CKSUM_EN
                        cksum    <= '0;
`endif
                    end
                end
                HDR: begin
                    if (word_full) begin
                        count <= word;
                        idx   <= '0;
                        if (word == 32'd0) begin
`ifdef INSTR_LOADER_CKSUM_EN
                            state <= CKSUM;
`else
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (word > CAPACITY) begin
                            state <= ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (byte_en) begin
`ifdef INSTR_LOADER_CKSUM_EN
                        cksum <= cksum ^ rx_data;
`endif
                        if (word_full) begin
                            state    <= WRITE;
                            im_we    <= 1'b1;
                            im_addr  <= idx[ADDR_W-1:0];
                            im_wdata <= word;
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
`ifdef INSTR_LOADER_CKSUM_EN
                        state <= CKSUM;
`else
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= LOAD;
                    end
                end
`ifdef INSTR_LOADER_CKSUM_EN
                CKSUM: begin
                    if (byte_en) begin
                        busy <= 1'b0;
                        if (rx_data == cksum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
